// File: rtl/mux2to1_rr.sv
// -----------------------------------------------------------------------------
// mux2to1_rr
//
// Merges two valid/ready input streams onto one registered output stream.
// It is the mirror image of a 1-to-2 stream demultiplexer. When both sources
// offer a beat in the same cycle, a round-robin arbiter picks the winner.
//
// The output stage is a single-entry register (EMPTY / FULL). It can accept a
// new beat in the same cycle that the sink drains the current one. This keeps
// throughput at one beat per clock while dout_ready stays high.
//
// Parameters
//   WIDTH       data width of both input streams and of the output stream
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   din0        data of source 0
//   valid0      source 0 offers din0
//   ready0      block accepts din0 this cycle
//   din1        data of source 1
//   valid1      source 1 offers din1
//   ready1      block accepts din1 this cycle
//   dout        merged output data (registered)
//   dout_valid  dout holds a beat
//   dout_sel    index of the source that produced the beat on dout
//   dout_ready  sink accepts dout this cycle
// -----------------------------------------------------------------------------
module mux2to1_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din0,
  input  logic             valid0,
  output logic             ready0,
  input  logic [WIDTH-1:0] din1,
  input  logic             valid1,
  output logic             ready1,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_sel,
  input  logic             dout_ready
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;     // source granted by the most recent input transfer
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             sel_q, sel_d;

  logic             can_load;
  logic             grant0, grant1;
  logic             xfer0, xfer1;
  logic             in_xfer, out_xfer;

  // ---------------------------------------------------------------------------
  // Arbitration and handshake
  // ---------------------------------------------------------------------------

  // The register can take a new beat when it is empty. It can also take one
  // when its current beat leaves on this same edge.
  assign can_load = (state_q == ST_EMPTY) || dout_ready;

  // NOTE: every signal driven in always_comb gets a default first. Without it,
  // any path that skips an assignment would infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case ({valid1, valid0})
      2'b01:   grant0 = 1'b1;
      2'b10:   grant1 = 1'b1;
      // Under contention, the source that lost last time wins. last_q resets
      // to 1, so source 0 wins the first contention.
      2'b11: begin
        if (last_q) grant0 = 1'b1;
        else        grant1 = 1'b1;
      end
      default: ;
    endcase
  end

  // The grant is never one-hot on a source whose valid is low, so both readies
  // fall to 0 whenever nothing is offered. Reset gates the readies
  // combinationally. While rst_n is low the register reads EMPTY, and without
  // this gate the block would appear ready.
  assign ready0   = rst_n & can_load & grant0;
  assign ready1   = rst_n & can_load & grant1;

  assign xfer0    = valid0 & ready0;
  assign xfer1    = valid1 & ready1;
  assign in_xfer  = xfer0 | xfer1;
  assign out_xfer = (state_q == ST_FULL) & dout_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic for the output register and the round-robin pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dout_d  = dout_q;
    sel_d   = sel_q;

    if (in_xfer) begin
      // A load wins over a drain. If the old beat leaves on this same edge,
      // the new one takes its place with no bubble.
      state_d = ST_FULL;
      last_d  = xfer1;
      sel_d   = xfer1;
      dout_d  = xfer1 ? din1 : din0;
    end else if (out_xfer) begin
      // Drained with nothing to replace it. The data and the source index keep
      // their stale values. They are meaningless while dout_valid is low.
      state_d = ST_EMPTY;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------

  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples values from before the edge, whatever order the blocks run in.
  // The asynchronous reset clears any held beat at once, with no clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      last_q  <= 1'b1;
      dout_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      sel_q   <= sel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dout       = dout_q;
  assign dout_sel   = sel_q;
  assign dout_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux2to1_rr.sv
// -----------------------------------------------------------------------------
// tb_mux2to1_rr
//
// Self-checking bench for mux2to1_rr with WIDTH=8. The test runs in three parts:
//   1. A directed table of {inputs, expected outputs}. It covers a single
//      source, contention, backpressure, drain-and-reload, and the pointer
//      holding during a stall.
//   2. A hand-written sequence that asserts reset in the middle of a cycle.
//   3. Randomized traffic. A reference model checks it: the model predicts the
//      readies from the grant rules and tracks every accepted beat in a
//      per-source queue.
// -----------------------------------------------------------------------------
module tb_mux2to1_rr;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din0, din1;
  logic             valid0, valid1;
  logic             ready0, ready1;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, dout_sel, dout_ready;

  int checks   = 0;
  int failures = 0;

  mux2to1_rr #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din0       (din0),
    .valid0     (valid0),
    .ready0     (ready0),
    .din1       (din1),
    .valid1     (valid1),
    .ready1     (ready1),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_sel   (dout_sel),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One directed step: the inputs for one cycle, the readies expected before
  // the edge, and the output register expected after the edge.
  typedef struct {
    logic             v0;
    logic [WIDTH-1:0] d0;
    logic             v1;
    logic [WIDTH-1:0] d1;
    logic             dr;
    logic             er0;
    logic             er1;
    logic             edv;
    logic             chk;   // compare dout/dout_sel after the edge
    logic [WIDTH-1:0] ed;
    logic             es;
  } vec_t;

  function automatic vec_t mk(logic v0, logic [WIDTH-1:0] d0, logic v1, logic [WIDTH-1:0] d1,
                              logic dr, logic er0, logic er1, logic edv, logic chk,
                              logic [WIDTH-1:0] ed, logic es);
    vec_t v;
    v.v0 = v0;   v.d0 = d0;   v.v1 = v1;   v.d1 = d1;   v.dr = dr;
    v.er0 = er0; v.er1 = er1; v.edv = edv; v.chk = chk; v.ed = ed; v.es = es;
    return v;
  endfunction

  // Reference model state for the random phase.
  logic             m_full;
  logic             m_last;
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  int               beats_in, beats_out;

  task automatic set_inputs(logic v0, logic [WIDTH-1:0] d0, logic v1, logic [WIDTH-1:0] d1, logic dr);
    valid0 = v0; din0 = d0; valid1 = v1; din1 = d1; dout_ready = dr;
  endtask

  initial begin
    vec_t vecs[15];
    string tag;

    // ---- reset state ----
    rst_n = 1'b0;
    set_inputs(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    #2;
    check("reset_ready0", 32'(ready0), 32'd0);
    check("reset_ready1", 32'(ready1), 32'd0);
    @(posedge clk); #1;
    check("reset_dout_valid", 32'(dout_valid), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_dout_sel", 32'(dout_sel), 32'd0);
    set_inputs(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- directed table ----
    //                v0   d0     v1   d1     dr   r0   r1   dv   chk  dout   sel
    vecs[0]  = mk(1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0);
    vecs[1]  = mk(1'b1, 8'h11, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 1'b1);
    vecs[2]  = mk(1'b1, 8'h11, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    vecs[3]  = mk(1'b1, 8'h12, 1'b1, 8'h21, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h21, 1'b1);
    vecs[4]  = mk(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
    vecs[5]  = mk(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
    vecs[6]  = mk(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
    vecs[7]  = mk(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
    vecs[8]  = mk(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
    vecs[9]  = mk(1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
    vecs[10] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    vecs[11] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    vecs[12] = mk(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1);
    vecs[13] = mk(1'b1, 8'h66, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1);
    vecs[14] = mk(1'b1, 8'h66, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66, 1'b0);

    for (int i = 0; i < 15; i++) begin
      tag = $sformatf("vec%0d", i);
      set_inputs(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].dr);
      @(negedge clk);
      check({tag, "_ready0"}, 32'(ready0), 32'(vecs[i].er0));
      check({tag, "_ready1"}, 32'(ready1), 32'(vecs[i].er1));
      @(posedge clk); #1;
      check({tag, "_dout_valid"}, 32'(dout_valid), 32'(vecs[i].edv));
      if (vecs[i].chk) begin
        check({tag, "_dout"}, 32'(dout), 32'(vecs[i].ed));
        check({tag, "_dout_sel"}, 32'(dout_sel), 32'(vecs[i].es));
      end
    end

    // ---- reset mid-stream: FULL (66 from source 0) and both valid, stalled ----
    set_inputs(1'b1, 8'hE1, 1'b1, 8'hE2, 1'b0);
    @(posedge clk); #2;
    check("pre_reset_full", 32'(dout_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_dout_valid", 32'(dout_valid), 32'd0);
    check("async_reset_dout", 32'(dout), 32'd0);
    check("async_reset_ready0", 32'(ready0), 32'd0);
    check("async_reset_ready1", 32'(ready1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_ready0", 32'(ready0), 32'd1);
    check("post_reset_ready1", 32'(ready1), 32'd0);
    @(posedge clk); #1;
    check("post_reset_dout_valid", 32'(dout_valid), 32'd1);
    check("post_reset_dout", 32'(dout), 32'hE1);
    check("post_reset_dout_sel", 32'(dout_sel), 32'd0);

    // ---- randomized scoreboard phase, starting from a clean reset ----
    set_inputs(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_full = 1'b0;
    m_last = 1'b1;
    beats_in = 0;
    beats_out = 0;

    for (int cyc = 0; cyc < 1010; cyc++) begin
      logic g0, g1, can, er0, er1;
      logic [WIDTH-1:0] exp_d;
      if (cyc < 1000)
        set_inputs(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)),
                   8'($urandom), 1'($urandom_range(3) != 0));
      else
        set_inputs(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);   // drain tail
      @(negedge clk);

      // Grant rules: a lone requester wins; under contention the other source
      // from the last winner wins.
      g0  = valid0 && (!valid1 || m_last);
      g1  = valid1 && (!valid0 || !m_last);
      can = !m_full || dout_ready;
      er0 = can && g0;
      er1 = can && g1;
      check("rnd_ready0", 32'(ready0), 32'(er0));
      check("rnd_ready1", 32'(ready1), 32'(er1));
      check("rnd_dout_valid", 32'(dout_valid), 32'(m_full));

      if (m_full && dout_ready) begin
        beats_out++;
        if (dout_sel == 1'b0 && q0.size() > 0) begin
          exp_d = q0.pop_front();
          check("rnd_dout_src0", 32'(dout), 32'(exp_d));
        end else if (dout_sel == 1'b1 && q1.size() > 0) begin
          exp_d = q1.pop_front();
          check("rnd_dout_src1", 32'(dout), 32'(exp_d));
        end else begin
          check("rnd_unexpected_beat_sel", 32'(dout_sel), 32'hFFFF);
        end
      end

      if (er0) begin q0.push_back(din0); beats_in++; m_last = 1'b0; end
      if (er1) begin q1.push_back(din1); beats_in++; m_last = 1'b1; end
      if (er0 || er1)       m_full = 1'b1;
      else if (dout_ready)  m_full = 1'b0;

      @(posedge clk); #1;
    end

    check("rnd_beats_in_eq_out", 32'(beats_out), 32'(beats_in));
    check("rnd_q0_empty", 32'(q0.size()), 32'd0);
    check("rnd_q1_empty", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
